// File: rtl/usb_pkg.sv
// Shared types and constants for the USB full-speed transmit path.
package usb_pkg;

  typedef enum logic [2:0] {
    PKT_NONE  = 3'd0,
    PKT_DATA0 = 3'd1,
    PKT_DATA1 = 3'd2,
    PKT_ACK   = 3'd3,
    PKT_NAK   = 3'd4,
    PKT_STALL = 3'd5
  } tx_packet_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SYNC   = 3'd1,
    ST_PID    = 3'd2,
    ST_DATA   = 3'd3,
    ST_CRC_LO = 3'd4,
    ST_CRC_HI = 3'd5,
    ST_EOP    = 3'd6,
    ST_DONE   = 3'd7
  } tx_state_t;

  localparam logic [7:0] SYNC_BYTE = 8'h80;
  localparam logic [7:0] PID_DATA0 = 8'hC3;
  localparam logic [7:0] PID_DATA1 = 8'h4B;
  localparam logic [7:0] PID_ACK   = 8'hD2;
  localparam logic [7:0] PID_NAK   = 8'h5A;
  localparam logic [7:0] PID_STALL = 8'h1E;

  localparam logic [15:0] CRC16_POLY = 16'h8005;
  localparam logic [15:0] CRC16_INIT = 16'hFFFF;

  function automatic logic [15:0] reflect16(input logic [15:0] v);
    logic [15:0] r;
    for (int i = 0; i < 16; i++) r[i] = v[15-i];
    return r;
  endfunction

  // USB shifts LSB first, so the register runs with the bit-reversed polynomial.
  localparam logic [15:0] CRC16_POLY_REFL = reflect16(CRC16_POLY);

  function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] data);
    logic [15:0] c;
    c = crc ^ {8'h00, data};
    for (int i = 0; i < 8; i++) c = c[0] ? ((c >> 1) ^ CRC16_POLY_REFL) : (c >> 1);
    return c;
  endfunction

  function automatic logic pkt_is_valid(input logic [2:0] t);
    return (t >= 3'd1) && (t <= 3'd5);
  endfunction

  function automatic logic pkt_is_data(input logic [2:0] t);
    return (t == 3'd1) || (t == 3'd2);
  endfunction

  function automatic logic [7:0] pid_byte(input logic [2:0] t);
    logic [7:0] p;
    case (t)
      3'd1:    p = PID_DATA0;
      3'd2:    p = PID_DATA1;
      3'd3:    p = PID_ACK;
      3'd4:    p = PID_NAK;
      3'd5:    p = PID_STALL;
      default: p = 8'h00;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/usb_crc16.sv
// Bytewise reflected CRC16 accumulator (one byte per cycle).
module usb_crc16 import usb_pkg::*; (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        clear,
  input  logic        en,
  input  logic [7:0]  data,
  output logic [15:0] crc
);

  logic [15:0] crc_q;

  // Accumulate one payload byte per enabled cycle; clear restarts a packet.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)     crc_q <= CRC16_INIT;
    else if (clear) crc_q <= CRC16_INIT;
    else if (en)    crc_q <= crc16_byte(crc_q, data);
  end

  assign crc = crc_q;

endmodule

// File: rtl/usb_tx_sequencer.sv
// Walks one full-speed packet out to the serializer byte by byte:
// SYNC, PID, payload popped from the TX buffer, CRC16, then EOP.
//
//   state  | meaning
//   IDLE   | waiting for tx_start with a valid packet type
//   SYNC   | presenting 0x80
//   PID    | presenting the PID byte
//   DATA   | presenting payload bytes, popping the next on each accept
//   CRC_LO | presenting inverted CRC low byte
//   CRC_HI | presenting inverted CRC high byte
//   EOP    | holding tx_eop until the serializer takes it
//   DONE   | one-cycle tx_done pulse
module usb_tx_sequencer import usb_pkg::*; #(
  parameter int MAX_DATA = 64
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       tx_start,
  input  logic [2:0] tx_packet,
  input  logic [6:0] buffer_occupancy,
  input  logic [7:0] tx_packet_data,
  input  logic       byte_ready,
  output logic       get_tx_packet_data,
  output logic [7:0] tx_byte,
  output logic       tx_byte_valid,
  output logic       tx_eop,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam logic [6:0] MAX_LEN = 7'(MAX_DATA);

  tx_state_t   state_q, state_d;
  tx_packet_t  pkt_q, pkt_d;
  logic [6:0]  len_q, len_d;
  logic [6:0]  rem_q, rem_d;
  logic [7:0]  byte_q, byte_d;
  logic        valid_q, valid_d;
  logic        eop_q, eop_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic        accept;
  logic        pop;
  logic        crc_clear;
  logic        crc_en;
  logic [15:0] crc;
  logic [15:0] crc_next;

  assign accept   = valid_q & byte_ready;
  // The last payload byte and CRC_LO leave on back-to-back cycles, so the
  // low CRC byte is taken from the value the accumulator is about to hold.
  assign crc_next = crc16_byte(crc, byte_q);

  usb_crc16 u_crc16 (
    .clk   (clk),
    .n_rst (n_rst),
    .clear (crc_clear),
    .en    (crc_en),
    .data  (byte_q),
    .crc   (crc)
  );

  // Next-state, output-register and buffer-pop decode.
  always_comb begin
    state_d   = state_q;
    pkt_d     = pkt_q;
    len_d     = len_q;
    rem_d     = rem_q;
    byte_d    = byte_q;
    valid_d   = valid_q;
    eop_d     = eop_q;
    done_d    = 1'b0;
    pop       = 1'b0;
    crc_clear = 1'b0;
    crc_en    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (tx_start && pkt_is_valid(tx_packet)) begin
          pkt_d     = tx_packet_t'(tx_packet);
          len_d     = pkt_is_data(tx_packet)
                      ? ((buffer_occupancy > MAX_LEN) ? MAX_LEN : buffer_occupancy)
                      : 7'd0;
          crc_clear = 1'b1;
          byte_d    = SYNC_BYTE;
          valid_d   = 1'b1;
          state_d   = ST_SYNC;
        end
      end
      ST_SYNC: begin
        if (accept) begin
          byte_d  = pid_byte(pkt_q);
          state_d = ST_PID;
        end
      end
      ST_PID: begin
        if (accept) begin
          if (!pkt_is_data(pkt_q)) begin
            byte_d  = 8'h00;
            valid_d = 1'b0;
            eop_d   = 1'b1;
            state_d = ST_EOP;
          end else if (len_q == 7'd0) begin
            byte_d  = ~crc[7:0];
            state_d = ST_CRC_LO;
          end else begin
            pop     = 1'b1;
            byte_d  = tx_packet_data;
            rem_d   = len_q;
            state_d = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (accept) begin
          crc_en = 1'b1;
          if (rem_q > 7'd1) begin
            pop    = 1'b1;
            byte_d = tx_packet_data;
            rem_d  = rem_q - 7'd1;
          end else begin
            byte_d  = ~crc_next[7:0];
            rem_d   = 7'd0;
            state_d = ST_CRC_LO;
          end
        end
      end
      ST_CRC_LO: begin
        if (accept) begin
          byte_d  = ~crc[15:8];
          state_d = ST_CRC_HI;
        end
      end
      ST_CRC_HI: begin
        if (accept) begin
          byte_d  = 8'h00;
          valid_d = 1'b0;
          eop_d   = 1'b1;
          state_d = ST_EOP;
        end
      end
      ST_EOP: begin
        if (byte_ready) begin
          eop_d   = 1'b0;
          done_d  = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
        eop_d   = 1'b0;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and registered outputs; reset aborts any packet in flight.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= ST_IDLE;
      pkt_q   <= PKT_NONE;
      len_q   <= 7'd0;
      rem_q   <= 7'd0;
      byte_q  <= 8'h00;
      valid_q <= 1'b0;
      eop_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pkt_q   <= pkt_d;
      len_q   <= len_d;
      rem_q   <= rem_d;
      byte_q  <= byte_d;
      valid_q <= valid_d;
      eop_q   <= eop_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign get_tx_packet_data = pop;
  assign tx_byte            = byte_q;
  assign tx_byte_valid      = valid_q;
  assign tx_eop             = eop_q;
  assign tx_busy            = busy_q;
  assign tx_done            = done_q;

endmodule

// File: tb/tb_usb_tx_sequencer.sv
// Self-checking bench for usb_tx_sequencer: table-driven packets, hand-written
// corner sequences and randomized packets against a byte-stream reference model.
module tb_usb_tx_sequencer;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       tx_start;
  logic [2:0] tx_packet;
  logic [6:0] buffer_occupancy;
  logic [7:0] tx_packet_data;
  logic       byte_ready;
  logic       get_tx_packet_data;
  logic [7:0] tx_byte;
  logic       tx_byte_valid;
  logic       tx_eop;
  logic       tx_busy;
  logic       tx_done;

  always #5 clk = ~clk;

  usb_tx_sequencer #(.MAX_DATA(64)) dut (
    .clk                (clk),
    .n_rst              (n_rst),
    .tx_start           (tx_start),
    .tx_packet          (tx_packet),
    .buffer_occupancy   (buffer_occupancy),
    .tx_packet_data     (tx_packet_data),
    .byte_ready         (byte_ready),
    .get_tx_packet_data (get_tx_packet_data),
    .tx_byte            (tx_byte),
    .tx_byte_valid      (tx_byte_valid),
    .tx_eop             (tx_eop),
    .tx_busy            (tx_busy),
    .tx_done            (tx_done)
  );

  // Data buffer model: head byte is always presented, pops advance the head.
  logic [7:0] buf_mem [0:127];
  int pop_cnt = 0;
  int pop_base = 0;
  always @(posedge clk) if (get_tx_packet_data === 1'b1) pop_cnt <= pop_cnt + 1;
  assign tx_packet_data = buf_mem[7'(pop_cnt - pop_base)];

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
  endtask

  // Reference model: the full expected byte stream for one packet.
  logic [7:0] exp_q[$];
  int         exp_len;

  function automatic void build_exp(input int ptype, input int occ);
    logic [7:0]  pid;
    logic [15:0] c;
    logic        fb;
    exp_q.delete();
    exp_len = 0;
    case (ptype)
      1: pid = 8'hC3;
      2: pid = 8'h4B;
      3: pid = 8'hD2;
      4: pid = 8'h5A;
      5: pid = 8'h1E;
      default: return;
    endcase
    exp_q.push_back(8'h80);
    exp_q.push_back(pid);
    if (ptype == 1 || ptype == 2) begin
      exp_len = (occ > 64) ? 64 : occ;
      c = 16'hFFFF;
      for (int k = 0; k < exp_len; k++) begin
        exp_q.push_back(buf_mem[k]);
        for (int b = 0; b < 8; b++) begin
          fb = c[0] ^ buf_mem[k][b];
          c  = c >> 1;
          if (fb) c = c ^ 16'hA001;
        end
      end
      c = ~c;
      exp_q.push_back(c[7:0]);
      exp_q.push_back(c[15:8]);
    end
  endfunction

  function automatic logic ready_for(input int mode, input int idx);
    case (mode)
      0:       return 1'b1;
      1:       return (idx % 4 == 0) || (idx % 4 == 3);
      default: return ($urandom_range(0, 3) != 0);
    endcase
  endfunction

  // Issue one packet, watch it to completion, then check it against the model.
  task automatic run_packet(input int ptype, input int occ, input int rmode,
                            input int inject_idx, input int exp_nbytes,
                            input int exp_pops, input bit fixed_buf);
    int idx, nbytes, done_idx, byte_err, pop_err, stab_err, busy_err, proto_err;
    int act_err, eop_acc, eop_ok, first_bad;
    logic prev_stall, acc, exp_pop, valid_pkt;
    logic [7:0] prev_byte;
    for (int i = 0; i < 128; i++) buf_mem[i] = fixed_buf ? 8'(i + 1) : 8'($urandom);
    build_exp(ptype, occ);
    valid_pkt = (exp_q.size() != 0);
    pop_base = pop_cnt;
    @(negedge clk);
    tx_start = 1'b1; tx_packet = 3'(ptype); buffer_occupancy = 7'(occ); byte_ready = 1'b0;
    @(negedge clk);
    tx_start = 1'b0;
    buffer_occupancy = 7'($urandom);
    idx = 0; nbytes = 0; done_idx = -1; byte_err = 0; pop_err = 0; stab_err = 0;
    busy_err = 0; proto_err = 0; act_err = 0; eop_acc = 0; eop_ok = 0; first_bad = -1;
    prev_stall = 1'b0; prev_byte = 8'h00;
    while (idx < 1500 && done_idx < 0) begin
      if (idx > 0) @(negedge clk);
      byte_ready = ready_for(rmode, idx);
      tx_start   = (idx == inject_idx);
      tx_packet  = 3'd3;
      #1;
      if (!valid_pkt) begin
        if (tx_busy || tx_byte_valid || tx_eop || tx_done || get_tx_packet_data) act_err++;
        if (idx >= 8) break;
      end else begin
        if (!tx_busy) busy_err++;
        if (prev_stall && (!tx_byte_valid || tx_byte != prev_byte)) stab_err++;
        if (tx_byte_valid && tx_eop) proto_err++;
        acc     = tx_byte_valid && byte_ready;
        exp_pop = acc && (exp_len > 0) && (nbytes >= 1) && (nbytes <= exp_len);
        if (get_tx_packet_data !== exp_pop) pop_err++;
        if (acc) begin
          if (nbytes >= exp_q.size() || tx_byte !== exp_q[nbytes]) begin
            byte_err++;
            if (first_bad < 0) begin
              first_bad = nbytes;
              $display("FAIL byte[%0d] type %0d: got 0x%02h expected 0x%02h", nbytes, ptype,
                       tx_byte, (nbytes < exp_q.size()) ? exp_q[nbytes] : 8'hxx);
            end
          end
          nbytes++;
        end
        if (tx_eop && byte_ready) eop_acc++;
        if (tx_done) begin
          done_idx = idx;
          eop_ok   = (eop_acc == 1) && (nbytes == exp_q.size());
        end
        prev_stall = tx_byte_valid && !byte_ready;
        prev_byte  = tx_byte;
      end
      idx++;
    end
    @(negedge clk);
    tx_start = 1'b0; byte_ready = 1'b1;
    #1;
    if (!valid_pkt) begin
      chk("no_activity", act_err, 0);
      chk("no_pops", pop_cnt - pop_base, 0);
    end else begin
      chk("done_seen", (done_idx >= 0), 1);
      chk("byte_count", nbytes, (exp_nbytes >= 0) ? exp_nbytes : exp_q.size());
      chk("byte_values", byte_err, 0);
      chk("pop_count", pop_cnt - pop_base, (exp_pops >= 0) ? exp_pops : exp_len);
      chk("pop_timing", pop_err, 0);
      chk("stall_stable", stab_err, 0);
      chk("busy_held", busy_err + proto_err, 0);
      chk("eop_before_done", eop_ok, 1);
      chk("idle_after_done", {tx_busy, tx_done, tx_byte_valid, tx_eop}, 0);
      if (rmode == 0) chk("latency", done_idx, exp_q.size() + 1);
    end
  endtask

  typedef struct {
    int ptype;
    int occ;
    int rmode;
    int exp_nbytes;
    int exp_pops;
  } vec_t;

  vec_t vecs [12];
  int   dn;

  initial begin
    vecs[0]  = '{3,  10, 0, 2,  0};   // ACK
    vecs[1]  = '{4,   0, 0, 2,  0};   // NAK
    vecs[2]  = '{5,   3, 2, 2,  0};   // STALL, random ready
    vecs[3]  = '{1,   0, 0, 4,  0};   // DATA0 empty: 80 C3 00 00
    vecs[4]  = '{2,   4, 0, 8,  4};   // DATA1 01 02 03 04
    vecs[5]  = '{1,  64, 1, 68, 64};  // full packet, ready 1-0-0-1
    vecs[6]  = '{2, 100, 0, 68, 64};  // occupancy above cap
    vecs[7]  = '{1, 127, 2, 68, 64};
    vecs[8]  = '{0,   5, 0, 0,  0};   // NONE
    vecs[9]  = '{7,   5, 0, 0,  0};
    vecs[10] = '{6,  40, 0, 0,  0};
    vecs[11] = '{2,   1, 1, 5,  1};

    n_rst = 1'b0; tx_start = 1'b0; tx_packet = 3'd0; buffer_occupancy = 7'd0; byte_ready = 1'b0;
    for (int i = 0; i < 128; i++) buf_mem[i] = 8'h00;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {tx_byte, tx_byte_valid, tx_eop, tx_busy, tx_done, get_tx_packet_data}, 0);
    n_rst = 1'b1;
    @(negedge clk);

    foreach (vecs[i])
      run_packet(vecs[i].ptype, vecs[i].occ, vecs[i].rmode, -1,
                 vecs[i].exp_nbytes, vecs[i].exp_pops, 1'b1);

    // tx_start while payload is streaming must not disturb the packet.
    run_packet(1, 8, 0, 4, 12, 8, 1'b0);
    // tx_start in the DONE cycle (index 3 for a token) must be ignored.
    run_packet(3, 0, 0, 3, 2, 0, 1'b0);

    // Reset in the middle of DATA aborts with no completion pulse.
    for (int i = 0; i < 128; i++) buf_mem[i] = 8'($urandom);
    pop_base = pop_cnt;
    @(negedge clk);
    tx_start = 1'b1; tx_packet = 3'd2; buffer_occupancy = 7'd20; byte_ready = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    repeat (5) @(negedge clk);
    chk("mid_data_busy", {tx_busy, tx_byte_valid}, 2'b11);
    n_rst = 1'b0;
    #1;
    chk("reset_abort", {tx_byte, tx_byte_valid, tx_eop, tx_busy, tx_done, get_tx_packet_data}, 0);
    @(negedge clk);
    n_rst = 1'b1;
    dn = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      if (tx_done || tx_busy || tx_byte_valid) dn++;
    end
    chk("no_done_after_reset", dn, 0);

    for (int r = 0; r < 25; r++)
      run_packet($urandom_range(0, 7), $urandom_range(0, 127),
                 ($urandom_range(0, 2) == 0) ? 0 : 2, -1, -1, -1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/usb_tx_sequencer.md
# usb_tx_sequencer

Sequences transmission of one USB full-speed packet from the TX data buffer to the bit-level serializer. On a start request it emits SYNC, PID, the buffered payload bytes (drawn one per cycle from the data buffer via `get_tx_packet_data`), the CRC16, and an EOP request. It sits between the protocol/AHB control logic that issues `tx_start` and the NRZI/bit-stuff serializer, and it is the only block that pops the TX side of the data buffer.

## Interface
- MAX_DATA, 64, maximum payload bytes per packet; the latched length is capped at this value.
- clk  in  1  system clock, rising edge.
- n_rst  in  1  asynchronous, active-low reset.
- tx_start  in  1  one-cycle start request; ignored while `tx_busy`=1.
- tx_packet  in  3  packet type sampled with `tx_start`: 0 NONE, 1 DATA0, 2 DATA1, 3 ACK, 4 NAK, 5 STALL, 6-7 treated as NONE.
- buffer_occupancy  in  7  byte count from the data buffer.
- tx_packet_data  in  8  buffer output byte, valid in the same cycle `get_tx_packet_data`=1.
- byte_ready  in  1  serializer accepts `tx_byte`/`tx_eop` this cycle.
- get_tx_packet_data  out  1  one-cycle buffer pop strobe.
- tx_byte  out  8  byte to the serializer, LSB transmitted first.
- tx_byte_valid  out  1  `tx_byte` is valid; held until accepted.
- tx_eop  out  1  EOP request; held until `byte_ready`.
- tx_busy  out  1  high in every state except IDLE.
- tx_done  out  1  one-cycle completion pulse.

## Operation
- States: IDLE, SYNC, PID, DATA, CRC_LO, CRC_HI, EOP, DONE.
- IDLE: on `tx_start` with a valid type, latch the type and `len = min(buffer_occupancy, MAX_DATA)` (DATA types only; tokens use len=0). Initialise CRC to 0xFFFF. Go to SYNC. NONE or invalid types stay in IDLE with no outputs.
- SYNC: `tx_byte`=0x80. PID: `tx_byte`= DATA0 0xC3, DATA1 0x4B, ACK 0xD2, NAK 0x5A, STALL 0x1E.
- Byte handshake: the byte is accepted when `tx_byte_valid & byte_ready`. `tx_byte` must not change while valid and not accepted.
- On PID acceptance:
  - Token types go to EOP.
  - A DATA type with len=0 goes to CRC_LO.
  - A DATA type with len>0 asserts `get_tx_packet_data` in that same cycle, loads `tx_byte <= tx_packet_data`, sets remaining = len, and goes to DATA.
- DATA: each accepted byte updates the CRC and decrements remaining.
  - If remaining > 1, pop and load the next byte in the same cycle, with no bubble.
  - If remaining = 1, go to CRC_LO.
- CRC16: polynomial x^16+x^15+x^2+1 (0x8005), reflected, init 0xFFFF, updated bytewise over payload only. Sent complemented: CRC_LO = low byte, then CRC_HI = high byte.
- EOP: `tx_byte_valid`=0 and `tx_eop`=1 until `byte_ready`, then DONE. DONE: `tx_done`=1 for one cycle, then IDLE.
- At most one pop per accepted byte; total pops per packet equal the latched len exactly. Later changes to `buffer_occupancy` are ignored.

## Timing
- Reset values: state IDLE, `tx_byte`=0x00, and all 1-bit outputs 0. Reset mid-packet aborts immediately to IDLE with no `tx_done`; already-popped bytes are lost.
- `tx_start` in cycle N gives SYNC valid in cycle N+1.
- With `byte_ready` held high, a packet of length L takes L+4 cycles of valid bytes, then 1 EOP cycle, then 1 DONE cycle. `tx_busy` is high from N+1 through the DONE cycle inclusive.
- `tx_start` asserted during DONE is ignored. It is accepted starting the first IDLE cycle.
- All outputs are registered, except `get_tx_packet_data`, which is decoded from state & handshake.

## Structure
- Shared package `usb_pkg`: the `tx_packet_t` enum, the PID byte constants, the SYNC constant 0x80, the CRC16 polynomial and init constants, and the `tx_state_t` enum.
- One sub-module, `usb_crc16`: clk, n_rst, clear, en, data[7:0], crc[15:0]. It performs a bytewise reflected update in one cycle.

## Test plan
- ACK: `tx_start`, type 3, `byte_ready`=1 -> bytes 0x80, 0xD2, then `tx_eop` 1 cycle, then `tx_done`; no pops.
- DATA0, occupancy 0 -> bytes 0x80, 0xC3, 0x00, 0x00, EOP, done.
- DATA1, occupancy 4, buffer bytes 01 02 03 04 -> bytes 80 4B 01 02 03 04 followed by CRC matching a reference model; exactly 4 pops, each coinciding with the preceding byte's acceptance.
- Occupancy 64 with `byte_ready` toggling 1-0-0-1 -> `tx_byte` stable while stalled, 64 pops, 68 bytes total.
- `tx_start` during DATA -> ignored. `n_rst` low mid-DATA -> all outputs 0 next edge, IDLE, no `tx_done`.
- Type NONE or type 7 -> no `tx_busy`, no outputs.
